// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the single-cycle core's data memory port onto a ready/valid,
//   byte-laned data bus. It stalls the core while a transfer is in flight.
//   Ports:
//     clock, reset                 core clock, synchronous active-high reset
//     read_enable, write_enable    load / store request from control
//     data_format                  funct3 (B, H, W, BU, HU)
//     address, write_data          ALU byte address, right-aligned rs2 data
//     read_data                    extended load result (valid in DONE)
//     stall                        hold PC/regfile this cycle
//     misaligned, bus_error        one-cycle fault pulses
//     bus_*                        ready/valid data bus master side
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  data_format,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_address,
  output logic        bus_write,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data
);

  typedef enum logic [1:0] {IDLE, REQUEST, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state, state_next;
  size_t       size;
  logic        req, aligned, timeout;
  logic [3:0]  be_new;
  logic [31:0] wd_new, load_ext;
  logic [2:0]  fmt_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req = read_enable | write_enable;

  // Low two funct3 bits pick the size; 011/110/111 fall into word.
  always_comb begin
    case (data_format[1:0])
      2'b00:   size = SZ_B;
      2'b01:   size = SZ_H;
      default: size = SZ_W;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    be_new  = 4'b1111;
    wd_new  = write_data;
    case (size)
      SZ_B: begin
        be_new = 4'b0001 << address[1:0];
        wd_new = {4{write_data[7:0]}};
      end
      SZ_H: begin
        aligned = ~address[0];
        be_new  = 4'b0011 << address[1:0];
        wd_new  = {2{write_data[15:0]}};
      end
      default: aligned = (address[1:0] == 2'b00);
    endcase
  end

  // Load lane extraction uses the format/offset latched at launch.
  assign ld_byte = 8'(bus_read_data >> {off_q, 3'b000});
  assign ld_half = off_q[1] ? bus_read_data[31:16] : bus_read_data[15:0];

  always_comb begin
    case (fmt_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b101:  load_ext = {16'h0, ld_half};
      default: load_ext = bus_read_data;
    endcase
  end

  assign timeout = (state == REQUEST) && !bus_ready &&
                   (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    bus_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req && aligned) begin
          stall      = 1'b1;
          state_next = REQUEST;
        end else if (req) begin
          misaligned = 1'b1;
        end
      end
      REQUEST: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready || timeout) state_next = DONE;
      end
      // Commit cycle: never relaunch, req still belongs to this instruction.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      bus_address     <= '0;
      bus_write       <= 1'b0;
      bus_byte_enable <= '0;
      bus_write_data  <= '0;
      read_data       <= '0;
      bus_error       <= 1'b0;
      cnt             <= '0;
      fmt_q           <= '0;
      off_q           <= '0;
    end else begin
      state     <= state_next;
      bus_error <= timeout;
      case (state)
        IDLE: begin
          if (req && aligned) begin
            bus_address     <= {address[31:2], 2'b00};
            bus_write       <= ~read_enable;  // both set -> load
            bus_byte_enable <= be_new;
            bus_write_data  <= wd_new;
            fmt_q           <= data_format;
            off_q           <= address[1:0];
          end
        end
        REQUEST: begin
          if (bus_ready) begin
            if (!bus_write) read_data <= load_ext;
            cnt <= '0;
          end else if (timeout) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_enable, write_enable;
  logic [2:0]  data_format;
  logic [31:0] address, write_data, read_data;
  logic        stall, misaligned, bus_error, bus_valid, bus_ready, bus_write;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_enable;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  logic [31:0] exp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .read_enable(read_enable), .write_enable(write_enable),
    .data_format(data_format), .address(address), .write_data(write_data),
    .read_data(read_data), .stall(stall), .misaligned(misaligned),
    .bus_error(bus_error), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_address(bus_address), .bus_write(bus_write),
    .bus_byte_enable(bus_byte_enable), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (bus_valid && bus_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drop_req();
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  // One complete access starting in IDLE (#1 after an edge); ends #1 after
  // the edge that returns to IDLE, with the request inputs left as driven.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] fmt, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input int waits, input logic [3:0] ebe,
                        input logic [31:0] eaddr, input logic [31:0] ewd,
                        input logic [31:0] erd);
    logic [31:0] e;
    read_enable = rd; write_enable = wr; data_format = fmt;
    address = addr; write_data = wd;
    exp_q.push_back(erd);
    #1;
    chk({tag, ".idle_stall"}, 32'(stall), 32'd1);
    step();
    chk({tag, ".valid"}, 32'(bus_valid), 32'd1);
    chk({tag, ".addr"}, bus_address, eaddr);
    chk({tag, ".be"}, 32'(bus_byte_enable), 32'(ebe));
    chk({tag, ".wdata"}, bus_write_data, ewd);
    chk({tag, ".write"}, 32'(bus_write), 32'(wr & ~rd));
    for (int i = 0; i < waits; i++) begin
      step();
      chk({tag, ".hold_valid"}, 32'(bus_valid), 32'd1);
      chk({tag, ".hold_addr"}, bus_address, eaddr);
      chk({tag, ".hold_be"}, 32'(bus_byte_enable), 32'(ebe));
      chk({tag, ".hold_wdata"}, bus_write_data, ewd);
    end
    bus_ready = 1'b1; bus_read_data = rdat;
    #1;
    chk({tag, ".req_stall"}, 32'(stall), 32'd1);
    step();
    bus_ready = 1'b0; bus_read_data = 32'h0;
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".done_valid"}, 32'(bus_valid), 32'd0);
    e = exp_q.pop_front();
    chk({tag, ".read_data"}, read_data, e);
    step();
  endtask

  task automatic misalign(input string tag, input logic [2:0] fmt, input logic [31:0] addr);
    read_enable = 1'b1; data_format = fmt; address = addr;
    #1;
    chk({tag, ".misaligned"}, 32'(misaligned), 32'd1);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".valid"}, 32'(bus_valid), 32'd0);
    drop_req();
    step();
    chk({tag, ".valid_after"}, 32'(bus_valid), 32'd0);
    chk({tag, ".pulse_end"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    int n, hs0;
    logic [31:0] e;
    reset = 1'b1; bus_ready = 1'b0; bus_read_data = 32'h0;
    read_enable = 1'b0; write_enable = 1'b0; data_format = 3'b010;
    address = 32'h0; write_data = 32'h0;
    step(); step();
    chk("rst.valid", 32'(bus_valid), 32'd0);
    chk("rst.error", 32'(bus_error), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.read_data", read_data, 32'h0);
    chk("rst.addr", bus_address, 32'h0);
    chk("rst.be", 32'(bus_byte_enable), 32'h0);
    chk("rst.wdata", bus_write_data, 32'h0);
    chk("rst.write", 32'(bus_write), 32'd0);
    reset = 1'b0;
    step();

    access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF);
    drop_req(); step();
    access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80);
    drop_req(); step();
    access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, 4'b1000, 32'h100, 32'h0, 32'h00000080);
    drop_req(); step();
    access("lh", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 4'b1100, 32'h100, 32'h0, 32'hFFFF80FF);
    drop_req(); step();
    access("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 32'h80FF9234, 0, 4'b0011, 32'h100, 32'h0, 32'h00009234);
    drop_req(); step();
    access("sh", 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, 4'b1100, 32'h200, 32'hABCDABCD, 32'h00009234);
    drop_req(); step();
    access("sb", 0, 1, 3'b000, 32'h205, 32'h12345678, 32'h0, 0, 4'b0010, 32'h204, 32'h78787878, 32'h00009234);
    drop_req(); step();
    // both enables set -> treated as a load
    access("both", 1, 1, 3'b010, 32'h300, 32'h55555555, 32'h0BADF00D, 0, 4'b1111, 32'h300, 32'h55555555, 32'h0BADF00D);
    drop_req(); step();

    misalign("lw_mis", 3'b010, 32'h101);
    misalign("lh_mis", 3'b001, 32'h301);
    misalign("undef_mis", 3'b111, 32'h402);

    // timeout: bus_ready never comes
    read_enable = 1'b1; data_format = 3'b010; address = 32'h400;
    #1;
    chk("to.idle_stall", 32'(stall), 32'd1);
    step();
    n = 0;
    while (bus_valid && n < 20) begin
      n++;
      step();
    end
    chk("to.valid_cycles", 32'(n), 32'd4);
    chk("to.bus_error", 32'(bus_error), 32'd1);
    chk("to.done_stall", 32'(stall), 32'd0);
    chk("to.read_data", read_data, 32'h0BADF00D);
    drop_req();
    step();
    chk("to.error_pulse_end", 32'(bus_error), 32'd0);

    // back-to-back loads with request held high
    hs0 = hs_cnt;
    access("b2b0", 1, 0, 3'b010, 32'h500, 32'h0, 32'h11111111, 0, 4'b1111, 32'h500, 32'h0, 32'h11111111);
    access("b2b1", 1, 0, 3'b010, 32'h504, 32'h0, 32'h22222222, 1, 4'b1111, 32'h504, 32'h0, 32'h22222222);
    drop_req();
    #1;
    chk("b2b.handshakes", 32'(hs_cnt - hs0), 32'd2);
    step();
    chk("b2b.idle_valid", 32'(bus_valid), 32'd0);

    // reset on the 2nd REQUEST cycle of a store
    write_enable = 1'b1; data_format = 3'b010; address = 32'h600; write_data = 32'hCAFEF00D;
    step();
    step();
    chk("rmid.valid_before", 32'(bus_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("rmid.valid", 32'(bus_valid), 32'd0);
    chk("rmid.error", 32'(bus_error), 32'd0);
    chk("rmid.read_data", read_data, 32'h0);
    reset = 1'b0; drop_req();
    #1;
    chk("rmid.stall", 32'(stall), 32'd0);
    step();
    chk("rmid.idle_valid", 32'(bus_valid), 32'd0);
    chk("rmid.idle_error", 32'(bus_error), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
